// File: rtl/tff_pkg.sv
// tff_pkg: shared direction encoding and parameter-legality limits for the T-FF counter
package tff_pkg;
  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;
  localparam int WIDTH_MIN = 1;
  localparam int WIDTH_MAX = 32;
  localparam longint MODULO_MIN = 2;
  localparam int PRESCALE_MIN = 1;
  localparam int PRESCALE_MAX = 65535;
endpackage

// File: rtl/t_ff.sv
// t_ff: T flip-flop with synchronous active-high reset
module t_ff (
  input  logic sysclk,
  input  logic rst,
  input  logic t,
  output logic q
);
  always_ff @(posedge sysclk) q <= rst ? 1'b0 : q ^ t;
endmodule

// File: rtl/param_tff_counter.sv
// param_tff_counter: prescaled modulo up/down counter built from per-bit T flip-flops
module param_tff_counter
  import tff_pkg::*;
#(
  parameter int     WIDTH    = 8,
  parameter longint MODULO   = 256,
  parameter int     PRESCALE = 1
) (
  input  logic             sysclk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] Q,
  output logic             tc
);
  localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULO - 1);
  localparam logic [15:0] PRE_LAST = 16'(PRESCALE - 1);
  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX || MODULO < MODULO_MIN ||
      MODULO > (longint'(1) << WIDTH) || PRESCALE < PRESCALE_MIN || PRESCALE > PRESCALE_MAX) begin : g_bad
    $fatal(1, "param_tff_counter: illegal parameter values");
  end
  logic [15:0] pre_q, pre_d;
  logic tc_q, tc_d, step, up, wrap;
  logic [WIDTH-1:0] t, lo_one, lo_zero, ld_val;
  assign up = up_dn == DIR_UP;
  assign step = en && !load && pre_q == PRE_LAST;
  assign wrap = up ? Q == MAX : Q == '0;
  assign ld_val = load_val > MAX ? MAX : load_val;
  always_comb begin
    lo_one = '0;
    lo_zero = '0;
    lo_one[0] = 1'b1;
    lo_zero[0] = 1'b1;
    for (int i = 1; i < WIDTH; i++) begin
      lo_one[i] = lo_one[i-1] & Q[i-1];
      lo_zero[i] = lo_zero[i-1] & ~Q[i-1];
    end
    t = load ? Q ^ ld_val : !step ? '0 : wrap ? (up ? Q : Q ^ MAX) : up ? lo_one : lo_zero;
    pre_d = load ? '0 : !en ? pre_q : pre_q == PRE_LAST ? '0 : pre_q + 16'd1;
    tc_d = step && wrap;
  end
  always_ff @(posedge sysclk) begin
    if (rst) begin
      pre_q <= '0;
      tc_q <= 1'b0;
    end else begin
      pre_q <= pre_d;
      tc_q <= tc_d;
    end
  end
  assign tc = tc_q;
  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    t_ff u_bit (.sysclk(sysclk), .rst(rst), .t(t[g]), .q(Q[g]));
  end
endmodule
